hazard_ctrl: RTL and testbench

- Parametrised pipeline hazard controller for the 5-stage MIPS core. It consumes the decoder's per-instruction D-stage tuple: source registers, T_use_rs/T_use_rt, destination address, T_new, and the MDU flags.
- It tracks in-flight writers across the post-D stages in an internal scoreboard and counts down their T_new values.
- It produces the global stall, the D-stage forward selects and the MDU busy interlock.
- It sits between the decoder and the pipeline registers, replacing ad-hoc stall logic.

---
 rtl/hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_hazard_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks post-D writers, raises stall, picks D-stage forward sources, interlocks the MDU.
// Optional `HAZARD_STATS_EN adds stall statistic counters (stat_data_stall, stat_mdu_stall).
module hazard_ctrl #(
  parameter int STAGES   = 3,
  parameter int AW       = 5,
  parameter int TW       = 2,
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int SW       = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] rs_D,
  input  logic [AW-1:0] rt_D,
  input  logic [TW-1:0] tuse_rs_D,
  input  logic [TW-1:0] tuse_rt_D,
  input  logic [AW-1:0] wa_D,
  input  logic [TW-1:0] tnew_D,
  input  logic          regwrite_D,
  input  logic          mdu_start_D,
  input  logic          mdu_div_D,
  input  logic          is_mdu_D,
  output logic          stall,
  output logic [SW-1:0] fwd_rs_sel,
  output logic [SW-1:0] fwd_rt_sel,
  output logic          mdu_busy
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]   stat_data_stall,
  output logic [31:0]   stat_mdu_stall
`endif
);

  localparam int CW = $clog2(DIV_CYC + 1);
  localparam logic [TW-1:0] TUSE_NONE = '1;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
    logic [TW-1:0] tnew;
  } entry_t;

  typedef struct packed {
    logic          stall;
    logic [SW-1:0] sel;
  } op_res_t;

  entry_t [STAGES-1:0] sb_q, sb_d;
  logic                mdu_start_q;
  logic [CW-1:0]       mdu_cnt_q;
  op_res_t             rs_res, rt_res;
  logic                data_stall, mdu_stall, stall_raw;

  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] x);
    return (x == '0) ? '0 : x - TW'(1);
  endfunction

  // Youngest (lowest index) matching writer decides; older matches are shadowed.
  function automatic op_res_t resolve(input logic [AW-1:0] r, input logic [TW-1:0] tuse,
                                      input entry_t [STAGES-1:0] sb);
    op_res_t res;
    logic    hit;
    res = '0;
    hit = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      if (!hit && sb[i].valid && (sb[i].addr == r) && (r != '0)) begin
        hit       = 1'b1;
        res.stall = (sb[i].tnew > tuse) && (tuse != TUSE_NONE);
        res.sel   = (sb[i].tnew == '0) ? SW'(i + 1) : '0;
      end
    end
    return res;
  endfunction

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    rs_res     = resolve(rs_D, tuse_rs_D, sb_q);
    rt_res     = resolve(rt_D, tuse_rt_D, sb_q);
    data_stall = rs_res.stall | rt_res.stall;
    mdu_stall  = is_mdu_D & ((mdu_cnt_q != '0) | mdu_start_q);
    stall_raw  = data_stall | mdu_stall;

    sb_d = '0;
    if (!stall_raw) begin
      sb_d[0].valid = regwrite_D && (wa_D != '0);
      sb_d[0].addr  = wa_D;
      sb_d[0].tnew  = sat_dec(tnew_D);
    end
    // Older entries advance and count down even while a bubble enters entry 0.
    for (int i = 1; i < STAGES; i++) begin
      sb_d[i]      = sb_q[i-1];
      sb_d[i].tnew = sat_dec(sb_q[i-1].tnew);
    end

    stall      = reset & stall_raw;
    fwd_rs_sel = reset ? rs_res.sel : '0;
    fwd_rt_sel = reset ? rt_res.sel : '0;
    mdu_busy   = reset & (mdu_cnt_q != '0);
  end

  // NOTE: state registers use non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sb_q        <= '0;
      mdu_start_q <= 1'b0;
      mdu_cnt_q   <= '0;
    end else begin
      sb_q        <= sb_d;
      mdu_start_q <= mdu_start_D & ~stall_raw;
      if (mdu_start_D && !stall_raw)
        mdu_cnt_q <= mdu_div_D ? CW'(DIV_CYC) : CW'(MULT_CYC);
      else if (mdu_cnt_q != '0)
        mdu_cnt_q <= mdu_cnt_q - CW'(1);
    end
  end

`ifdef HAZARD_STATS_EN
  // Data stalls take precedence; MDU-only stall cycles are counted separately.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_data_stall <= '0;
      stat_mdu_stall  <= '0;
    end else if (data_stall) begin
      stat_data_stall <= stat_data_stall + 32'd1;
    end else if (mdu_stall) begin
      stat_mdu_stall  <= stat_mdu_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: expected outputs are queued per D-stage step and checked mid-cycle.
module tb_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] rs_D, rt_D, wa_D;
  logic [1:0] tuse_rs_D, tuse_rt_D, tnew_D;
  logic       regwrite_D, mdu_start_D, mdu_div_D, is_mdu_D;
  logic       stall, mdu_busy;
  logic [1:0] fwd_rs_sel, fwd_rt_sel;

  typedef struct packed {
    logic       stall;
    logic [1:0] rs_sel;
    logic [1:0] rt_sel;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;

  hazard_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .rs_D        (rs_D),
    .rt_D        (rt_D),
    .tuse_rs_D   (tuse_rs_D),
    .tuse_rt_D   (tuse_rt_D),
    .wa_D        (wa_D),
    .tnew_D      (tnew_D),
    .regwrite_D  (regwrite_D),
    .mdu_start_D (mdu_start_D),
    .mdu_div_D   (mdu_div_D),
    .is_mdu_D    (is_mdu_D),
    .stall       (stall),
    .fwd_rs_sel  (fwd_rs_sel),
    .fwd_rt_sel  (fwd_rt_sel),
    .mdu_busy    (mdu_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] expv);
    n_total++;
    assert (got === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [1:0] tu_rs,
                       input logic [4:0] rt, input logic [1:0] tu_rt,
                       input logic [4:0] wa, input logic [1:0] tn, input logic rw,
                       input logic ms, input logic md, input logic im);
    rs_D = rs;  tuse_rs_D = tu_rs;
    rt_D = rt;  tuse_rt_D = tu_rt;
    wa_D = wa;  tnew_D = tn;  regwrite_D = rw;
    mdu_start_D = ms;  mdu_div_D = md;  is_mdu_D = im;
  endtask

  task automatic idle();
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Queue the expectation for the currently driven D inputs, check mid-cycle, then move past the edge.
  task automatic step(input string tag, input logic e_stall, input logic [1:0] e_rs,
                      input logic [1:0] e_rt, input logic e_busy);
    exp_t e;
    exp_q.push_back('{stall: e_stall, rs_sel: e_rs, rt_sel: e_rt, busy: e_busy});
    @(negedge clk);
    e = exp_q.pop_front();
    chk({tag, ".stall"},  {1'b0, stall},    {1'b0, e.stall});
    chk({tag, ".rs_sel"}, fwd_rs_sel,       e.rs_sel);
    chk({tag, ".rt_sel"}, fwd_rt_sel,       e.rt_sel);
    chk({tag, ".busy"},   {1'b0, mdu_busy}, {1'b0, e.busy});
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 3; i++) step("drain", 1'b0, 2'd0, 2'd0, 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    drive(5'd8, 2'd0, 5'd9, 2'd0, 5'd8, 2'd3, 1'b1, 1'b1, 1'b1, 1'b1);
    step("in_reset", 1'b0, 2'd0, 2'd0, 1'b0);
    reset = 1'b1;
    idle();
    step("reset_state", 1'b0, 2'd0, 2'd0, 1'b0);

    // lw $8 (tnew 3) followed by a reader with tuse 1
    drive(5'd29, 2'd1, 5'd0, 2'd3, 5'd8, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    step("lw_issue", 1'b0, 2'd0, 2'd0, 1'b0);
    drive(5'd8, 2'd1, 5'd0, 2'd1, 5'd10, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    step("lw_use_stall", 1'b1, 2'd0, 2'd0, 1'b0);
    step("lw_use_go", 1'b0, 2'd0, 2'd0, 1'b0);
    drive(5'd8, 2'd0, 5'd10, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("fwd_w_and_e", 1'b0, 2'd3, 2'd1, 1'b0);
    drain();

    // add $9 (tnew 2) followed by beq with tuse 0
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd9, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    step("add_issue", 1'b0, 2'd0, 2'd0, 1'b0);
    drive(5'd9, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("beq_stall", 1'b1, 2'd0, 2'd0, 1'b0);
    step("beq_fwd_m", 1'b0, 2'd2, 2'd0, 1'b0);
    drain();

    // $0 writer never matches; unused operand never stalls
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    step("w_zero", 1'b0, 2'd0, 2'd0, 1'b0);
    drive(5'd0, 2'd0, 5'd0, 2'd0, 5'd7, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    step("r_zero", 1'b0, 2'd0, 2'd0, 1'b0);
    drive(5'd7, 2'd3, 5'd7, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("tuse_unused", 1'b0, 2'd0, 2'd0, 1'b0);
    drain();

    // Two writers to $5: youngest wins; also no self-match on rs==wa_D
    drive(5'd5, 2'd0, 5'd0, 2'd3, 5'd5, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    step("no_self_match", 1'b0, 2'd0, 2'd0, 1'b0);
    drive(5'd5, 2'd0, 5'd0, 2'd3, 5'd5, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    step("fwd_e_first", 1'b0, 2'd1, 2'd0, 1'b0);
    drive(5'd5, 2'd0, 5'd5, 2'd1, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("youngest_wins", 1'b0, 2'd1, 2'd1, 1'b0);
    drain();

    // Young $6 writer with tnew>0 shadows an older ready one
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd6, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    step("w6_old", 1'b0, 2'd0, 2'd0, 1'b0);
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd6, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    step("w6_young", 1'b0, 2'd0, 2'd0, 1'b0);
    drive(5'd6, 2'd2, 5'd6, 2'd1, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("shadow_stall", 1'b1, 2'd0, 2'd0, 1'b0);
    step("shadow_release", 1'b0, 2'd0, 2'd0, 1'b0);
    drain();

    // div then mfhi: 10 busy cycles
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    step("div_issue", 1'b0, 2'd0, 2'd0, 1'b0);
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd11, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) step("mfhi_wait", 1'b1, 2'd0, 2'd0, 1'b1);
    step("mfhi_go", 1'b0, 2'd0, 2'd0, 1'b0);

    // mult: 5 busy cycles, non-MDU instructions flow meanwhile
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    step("mult_issue", 1'b0, 2'd0, 2'd0, 1'b0);
    idle();
    for (int k = 0; k < 5; k++) step("mult_busy", 1'b0, 2'd0, 2'd0, 1'b1);
    step("mult_done", 1'b0, 2'd0, 2'd0, 1'b0);
    drain();

    // Reset during a div countdown with a pending lw hazard
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    step("rst_div", 1'b0, 2'd0, 2'd0, 1'b0);
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    step("rst_lw", 1'b0, 2'd0, 2'd0, 1'b1);
    drive(5'd8, 2'd1, 5'd0, 2'd3, 5'd12, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    step("rst_pending", 1'b1, 2'd0, 2'd0, 1'b1);
    reset = 1'b0;
    step("rst_forced", 1'b0, 2'd0, 2'd0, 1'b0);
    reset = 1'b1;
    drive(5'd8, 2'd0, 5'd8, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("rst_clean", 1'b0, 2'd0, 2'd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
